// File: rtl/led_pkg.sv
// Shared types for the status LED controller: channel state encoding and
// {r,g,b} colour constants.
package led_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        FAULT = 2'd2,
        FIXED = 2'd3
    } led_state_e;

    typedef logic [2:0] rgb_t;

    localparam rgb_t OFF   = 3'b000;
    localparam rgb_t RED   = 3'b100;
    localparam rgb_t GREEN = 3'b010;
    localparam rgb_t BLUE  = 3'b001;

    // Steady-state colour of one channel; FAULT is gated by the blink phase
    // only when blinking is enabled.
    function automatic rgb_t state_colour(input led_state_e st,
                                          input logic       blink_en,
                                          input logic       phase);
        rgb_t c;
        case (st)
            ARMED:   c = RED;
            FAULT:   c = BLUE & {3{phase | ~blink_en}};
            FIXED:   c = GREEN;
            default: c = OFF;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/blink_timer.sv
// Free-running half-period counter producing a square-wave blink phase;
// a clear pulse restarts the count at zero with the phase low.
module blink_timer
    import led_pkg::*;
#(
    parameter int HALF_PERIOD = 50_000_000
) (
    input  logic clk_50M,
    input  logic rst_n,
    input  logic clear,
    output logic phase
);

    localparam int            CW   = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
    localparam logic [CW-1:0] LAST = CW'(HALF_PERIOD - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          phase_q, phase_d;
    logic          wrap;

    always_comb begin
        wrap    = (cnt_q == LAST);
        cnt_d   = wrap ? '0 : cnt_q + CW'(1);
        phase_d = phase_q ^ wrap;
        if (clear) begin
            cnt_d   = '0;
            phase_d = 1'b0;
        end
    end

    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    assign phase = phase_q;

endmodule

// File: rtl/status_led_ctrl.sv
// Per-channel RGB status indicator: IDLE/ARMED/FAULT/FIXED tracking with an
// end-of-run override that blinks every channel green in unison.
module status_led_ctrl
    import led_pkg::*;
#(
    parameter int N_CH        = 3,
    parameter int HALF_PERIOD = 50_000_000,
    parameter int FAULT_BLINK = 0
) (
    input  logic                clk_50M,
    input  logic                rst_n,
    input  logic [N_CH-1:0]     arm,
    input  logic [N_CH-1:0]     fault_detect,
    input  logic [N_CH-1:0]     object_drop,
    input  logic                run_complete,
    output logic [N_CH-1:0]     led_r,
    output logic [N_CH-1:0]     led_g,
    output logic [N_CH-1:0]     led_b,
    output logic [2*N_CH-1:0]   ch_state
);

    localparam logic BLINK_EN = (FAULT_BLINK != 0);

    logic done_q, done_d;
    logic phase;

    always_comb done_d = done_q | run_complete;

    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) done_q <= 1'b0;
        else        done_q <= done_d;
    end

    // Restarting the timer on run_complete guarantees a full dark half-period
    // before the first green flash.
    blink_timer #(
        .HALF_PERIOD (HALF_PERIOD)
    ) u_blink (
        .clk_50M (clk_50M),
        .rst_n   (rst_n),
        .clear   (run_complete),
        .phase   (phase)
    );

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        led_state_e state_q, state_d;
        rgb_t       colour;

        // object_drop is checked first so it wins over a coincident fault.
        always_comb begin
            state_d = state_q;
            case (state_q)
                IDLE:    if (arm[i]) state_d = ARMED;
                ARMED: begin
                    if (object_drop[i])       state_d = FIXED;
                    else if (fault_detect[i]) state_d = FAULT;
                end
                FAULT:   if (object_drop[i]) state_d = FIXED;
                FIXED:   state_d = FIXED;
                default: state_d = IDLE;
            endcase
        end

        always_ff @(posedge clk_50M or negedge rst_n) begin
            if (!rst_n) state_q <= IDLE;
            else        state_q <= state_d;
        end

        // LEDs decode only flop outputs, so they change exactly one edge after
        // the causing input and clear at once with reset.
        always_comb begin
            colour = state_colour(state_q, BLINK_EN, phase);
            if (done_q) colour = {1'b0, phase, 1'b0};
        end

        assign led_r[i]           = colour[2];
        assign led_g[i]           = colour[1];
        assign led_b[i]           = colour[0];
        assign ch_state[2*i +: 2] = state_q;
    end

endmodule

// File: tb/tb_status_led_ctrl.sv
// Scoreboard bench: stimulus queues expected outputs per cycle, a negedge
// monitor pops and compares both a solid-fault and a blinking-fault instance.
module tb_status_led_ctrl;

    localparam int N  = 3;
    localparam int HP = 4;

    logic         clk_50M = 1'b0;
    logic         rst_n;
    logic [N-1:0] arm, fd, od;
    logic         rc;
    logic [N-1:0] r0, g0, b0, r1, g1, b1;
    logic [2*N-1:0] s0, s1;

    status_led_ctrl #(.N_CH(N), .HALF_PERIOD(HP), .FAULT_BLINK(0)) dut0 (
        .clk_50M(clk_50M), .rst_n(rst_n), .arm(arm), .fault_detect(fd),
        .object_drop(od), .run_complete(rc),
        .led_r(r0), .led_g(g0), .led_b(b0), .ch_state(s0)
    );

    status_led_ctrl #(.N_CH(N), .HALF_PERIOD(HP), .FAULT_BLINK(1)) dut1 (
        .clk_50M(clk_50M), .rst_n(rst_n), .arm(arm), .fault_detect(fd),
        .object_drop(od), .run_complete(rc),
        .led_r(r1), .led_g(g1), .led_b(b1), .ch_state(s1)
    );

    always #5 clk_50M = ~clk_50M;

    int cyc = 0;
    always @(posedge clk_50M) cyc <= cyc + 1;

    typedef struct {
        int         tgt;
        string      name;
        logic [2:0] r, g, b, b1;
        logic [5:0] st;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   base  = 0;   // cycle at which the blink counter was last zero with phase 0

    function automatic logic ph(input int m);
        return (((m - base) / HP) % 2) == 1;
    endfunction

    task automatic expect_at(input int dly, input string name,
                             input logic [2:0] r, input logic [2:0] g,
                             input logic [2:0] b, input logic [2:0] bb,
                             input logic [5:0] st);
        exp_t e;
        e.tgt = cyc + dly; e.name = name;
        e.r = r; e.g = g; e.b = b; e.b1 = bb; e.st = st;
        sb.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk_50M);
            #1;
        end
    endtask

    task automatic pulse(input logic [2:0] a, input logic [2:0] f,
                         input logic [2:0] o, input logic c);
        arm = a; fd = f; od = o; rc = c;
        step(1);
        arm = '0; fd = '0; od = '0; rc = 1'b0;
    endtask

    always @(negedge clk_50M) begin
        exp_t e;
        while (sb.size() > 0 && sb[0].tgt <= cyc) begin
            e = sb.pop_front();
            n_cmp++;
            if (e.tgt < cyc) begin
                n_bad++;
                $display("FAIL %s: sample window missed (target %0d, now %0d)", e.name, e.tgt, cyc);
            end else begin
                if ({r0, g0, b0, s0} !== {e.r, e.g, e.b, e.st}) begin
                    n_bad++;
                    $display("FAIL %s solid@%0d: got r=%b g=%b b=%b st=%b, want r=%b g=%b b=%b st=%b",
                             e.name, cyc, r0, g0, b0, s0, e.r, e.g, e.b, e.st);
                end
                n_cmp++;
                if ({r1, g1, b1, s1} !== {e.r, e.g, e.b1, e.st}) begin
                    n_bad++;
                    $display("FAIL %s blink@%0d: got r=%b g=%b b=%b st=%b, want r=%b g=%b b=%b st=%b",
                             e.name, cyc, r1, g1, b1, s1, e.r, e.g, e.b1, e.st);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; arm = '0; fd = '0; od = '0; rc = 1'b0;
        step(2);
        expect_at(0, "reset_hold", 3'b000, 3'b000, 3'b000, 3'b000, 6'b000000);
        step(1);
        rst_n = 1'b1;
        base  = cyc;

        // Quiet after reset
        expect_at(1,  "idle_1",  3'b000, 3'b000, 3'b000, 3'b000, 6'b000000);
        expect_at(20, "idle_20", 3'b000, 3'b000, 3'b000, 3'b000, 6'b000000);
        step(20);

        // Channel 0 walk; fault/drop on idle channels 1/2 must be ignored
        expect_at(0, "ch0_pre_arm", 3'b000, 3'b000, 3'b000, 3'b000, 6'b000000);
        expect_at(1, "ch0_armed",   3'b001, 3'b000, 3'b000, 3'b000, 6'b000001);
        pulse(3'b001, 3'b010, 3'b100, 1'b0);
        step(2);
        expect_at(0, "ch0_pre_fault", 3'b001, 3'b000, 3'b000, 3'b000, 6'b000001);
        expect_at(1, "ch0_fault", 3'b000, 3'b000, 3'b001, {2'b00, ph(cyc + 1)}, 6'b000010);
        pulse(3'b000, 3'b001, 3'b000, 1'b0);
        step(2);
        expect_at(0, "ch0_fault_hold", 3'b000, 3'b000, 3'b001, {2'b00, ph(cyc)}, 6'b000010);
        expect_at(1, "ch0_fixed", 3'b000, 3'b001, 3'b000, 3'b000, 6'b000011);
        pulse(3'b000, 3'b000, 3'b001, 1'b0);

        // Channel 1: fault and drop together -> straight to FIXED
        expect_at(1, "ch1_armed", 3'b010, 3'b001, 3'b000, 3'b000, 6'b000111);
        pulse(3'b010, 3'b000, 3'b000, 1'b0);
        step(1);
        expect_at(1, "ch1_both_fixed", 3'b000, 3'b011, 3'b000, 3'b000, 6'b001111);
        expect_at(2, "ch1_fixed_hold", 3'b000, 3'b011, 3'b000, 3'b000, 6'b001111);
        pulse(3'b000, 3'b010, 3'b010, 1'b0);
        step(2);

        // Channel 2 FAULT blinking; re-arm of FIXED channel 0 ignored
        expect_at(1, "ch2_armed", 3'b100, 3'b011, 3'b000, 3'b000, 6'b011111);
        pulse(3'b100, 3'b000, 3'b000, 1'b0);
        step(1);
        for (int d = 1; d <= 8; d++)
            expect_at(d, "ch2_fault_blink", 3'b000, 3'b011, 3'b100, {ph(cyc + d), 2'b00}, 6'b101111);
        pulse(3'b001, 3'b100, 3'b000, 1'b0);
        step(8);

        // End of run: unison green blink, channel 2 still advances underneath
        base = cyc + 1;
        for (int d = 1; d <= 12; d++)
            expect_at(d, "done_blink", 3'b000, {3{ph(cyc + d)}}, 3'b000, 3'b000,
                      (d >= 6) ? 6'b111111 : 6'b101111);
        pulse(3'b000, 3'b000, 3'b000, 1'b1);
        step(4);
        pulse(3'b000, 3'b000, 3'b100, 1'b0);
        step(7);

        // Asynchronous reset between edges while green is lit
        expect_at(0, "async_reset", 3'b000, 3'b000, 3'b000, 3'b000, 6'b000000);
        #3 rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
        base  = cyc;
        expect_at(0, "post_reset",    3'b000, 3'b000, 3'b000, 3'b000, 6'b000000);
        expect_at(1, "rearm",         3'b010, 3'b000, 3'b000, 3'b000, 6'b000100);
        expect_at(6, "rearm_no_done", 3'b010, 3'b000, 3'b000, 3'b000, 6'b000100);
        pulse(3'b010, 3'b000, 3'b000, 1'b0);
        step(8);

        while (sb.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: expectation never checked (target %0d)", sb[0].name, sb[0].tgt);
            void'(sb.pop_front());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/status_led_ctrl.md
STATUS_LED_CTRL -- requirements
Module: status_led_ctrl

Interface
REQ-001 The block SHALL have parameter N_CH, default 3, giving the number of RGB status channels (1..8).
REQ-002 The block SHALL have parameter HALF_PERIOD, default 50_000_000, giving clk_50M cycles per blink half-period (>=2).
REQ-003 The block SHALL have parameter FAULT_BLINK, default 0, which makes the FAULT colour blink when set to 1 and hold solid when 0.
REQ-004 The block SHALL have port clk_50M, input, 1 bit: the single system clock; all logic SHALL be rising-edge clocked.
REQ-005 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 The block SHALL have port arm, input, N_CH bits: per-channel unit-fault-flag pulse that arms the channel.
REQ-007 The block SHALL have port fault_detect, input, N_CH bits: per-channel pulse, fault found.
REQ-008 The block SHALL have port object_drop, input, N_CH bits: per-channel pulse, fault rectified.
REQ-009 The block SHALL have port run_complete, input, 1 bit: pulse, end of run.
REQ-010 The block SHALL have ports led_r, led_g, led_b, each output, N_CH bits: per-channel colour drives, active-high.
REQ-011 The block SHALL have port ch_state, output, 2*N_CH bits: per-channel state code, channel i in bits [2i+1:2i].

Function
REQ-012 Each channel SHALL run an independent FSM with states IDLE=0, ARMED=1, FAULT=2, FIXED=3.
REQ-013 IDLE SHALL go to ARMED on arm[i]; fault_detect[i] and object_drop[i] SHALL be ignored in IDLE.
REQ-014 ARMED SHALL go to FAULT on fault_detect[i] and to FIXED on object_drop[i]; if both are high in the same cycle, FIXED SHALL win.
REQ-015 FAULT SHALL go to FIXED on object_drop[i]; FIXED SHALL be terminal until reset, with a repeated arm ignored.
REQ-016 Colours per channel SHALL be: IDLE off (000); ARMED red (100); FAULT blue (001), ANDed with blink phase when FAULT_BLINK=1; FIXED green (010). Bit order is {r,g,b}.
REQ-017 Outputs SHALL be registered; a state-changing input sampled at edge k SHALL show on the LEDs and ch_state after edge k, i.e. one-cycle latency.
REQ-018 A free-running blink counter SHALL count 0..HALF_PERIOD-1, wrap to 0, and toggle phase on the wrap cycle; its width SHALL be $clog2(HALF_PERIOD).
REQ-019 run_complete SHALL set a sticky done flag; while done=1, every channel SHALL output {0,phase,0} (all green blinking in unison), overriding its state colour.
REQ-020 On the cycle run_complete is sampled, the blink counter and phase SHALL be cleared, so green is off for exactly HALF_PERIOD cycles, then on for HALF_PERIOD.
REQ-021 Per-channel FSMs SHALL keep advancing while done=1, and ch_state SHALL remain accurate.
REQ-022 Multi-bit pulse inputs SHALL be treated per bit; events on different channels in the same cycle SHALL all take effect.
REQ-023 Inputs SHALL be single-cycle pulses, synchronous to clk_50M; a held level SHALL behave as one event, since FSM transitions are edge-free but idempotent.

Reset
REQ-024 While rst_n=0, all FSMs SHALL be IDLE, done=0, the blink counter 0, phase 0, and led_r/led_g/led_b/ch_state all 0, asynchronously.
REQ-025 Reset asserted mid-run or mid-blink SHALL abandon all state immediately; after release, the first event SHALL be accepted at the first clock edge.

Structure
REQ-026 The package led_pkg SHALL hold the state enum (IDLE/ARMED/FAULT/FIXED) and colour constants OFF, RED, GREEN, BLUE as 3-bit {r,g,b}.
REQ-027 Blink counter and phase SHALL live in sub-module blink_timer (params HALF_PERIOD; ports clk_50M, rst_n, clear, phase), instantiated once.
REQ-028 Per-channel FSM logic SHALL be generated N_CH times inside status_led_ctrl, with no per-channel sub-module.

Verification (N_CH=3, HALF_PERIOD=4 unless stated)
REQ-029 Reset release, no stimulus for 20 cycles -> all LED outputs 0, ch_state=6'b000000.
REQ-030 arm=3'b001; 3 cycles later fault_detect=3'b001; 3 cycles later object_drop=3'b001 -> channel 0 shows 100, then 001, then 010, each one cycle after its pulse; channels 1-2 stay 000.
REQ-031 Channel 1 ARMED, then fault_detect[1] and object_drop[1] in the same cycle -> ch_state[3:2]=3 (FIXED) and led_g[1]=1; FAULT is never shown.
REQ-032 FAULT_BLINK=1, channel 2 in FAULT -> led_b[2] toggles every 4 cycles (pattern 0000 1111 repeating).
REQ-033 run_complete pulse with channels in mixed states -> led_g=000 for 4 cycles, then 111 for 4, repeating; led_r=led_b=000; ch_state unchanged.
REQ-034 rst_n pulled low mid-blink, between clock edges -> outputs 0 without waiting for a clock; after release, done=0 and arm is accepted again.
